cond_adder_initiator: RTL and testbench

// - Requester side of the conditional-sum adder start/complete handshake.
// - Accepts operand requests over valid/ready and drives ope1/ope2/add_sub/Cin/start into conditional_sum_adder_64.
// - Waits for complete, captures sum/cout/overf and returns them over a valid/ready response port.
// - Times out if the adder never answers; one transaction in flight at a time.

---
 rtl/cond_adder_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_cond_adder_initiator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cond_adder_initiator.sv
// Requester side of the conditional-sum adder start/complete handshake: one operation in flight,
// bounded wait on complete. Define CHECK_EN to add the golden-model result checker and error counter.
module cond_adder_initiator #(
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 16
`ifdef CHECK_EN
    ,
    parameter int ERR_W   = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_sub,
    output logic [WIDTH-1:0] ope1,
    output logic [WIDTH-1:0] ope2,
    output logic             add_sub,
    output logic             Cin,
    output logic             start,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    input  logic             overf_in,
    input  logic             complete_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_overf,
    output logic             rsp_timeout,
    output logic             busy
`ifdef CHECK_EN
    ,
    output logic             chk_mismatch,
    output logic [ERR_W-1:0] err_count
`endif
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [TW-1:0]    timer_r;
    logic             timer_last_s;
    logic [WIDTH-1:0] ope1_r;
    logic [WIDTH-1:0] ope2_r;
    logic             add_sub_r;
    logic [WIDTH-1:0] rsp_sum_r;
    logic             rsp_cout_r;
    logic             rsp_overf_r;
    logic             rsp_timeout_r;

    assign timer_last_s = (timer_r == TW'(TIMEOUT - 1));
    assign ope1         = ope1_r;
    assign ope2         = ope2_r;
    assign add_sub      = add_sub_r;
    assign Cin          = 1'b0;
    assign rsp_sum      = rsp_sum_r;
    assign rsp_cout     = rsp_cout_r;
    assign rsp_overf    = rsp_overf_r;
    assign rsp_timeout  = rsp_timeout_r;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a complete in the final timer cycle beats the timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) state_s = S_ISSUE;
                else           state_s = S_IDLE;
            end
            S_ISSUE: state_s = S_WAIT;
            S_WAIT: begin
                if (complete_in || timer_last_s) state_s = S_RESP;
                else                             state_s = S_WAIT;
            end
            S_RESP: begin
                if (rsp_ready) state_s = S_IDLE;
                else           state_s = S_RESP;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        req_ready = 1'b0;
        start     = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_r)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_ISSUE: start     = 1'b1;
            S_WAIT:  start     = 1'b0;
            S_RESP:  rsp_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Operand latch, wait timer and response capture
    always_ff @(posedge clock) begin
        if (reset) begin
            ope1_r        <= {WIDTH{1'b0}};
            ope2_r        <= {WIDTH{1'b0}};
            add_sub_r     <= 1'b0;
            timer_r       <= {TW{1'b0}};
            rsp_sum_r     <= {WIDTH{1'b0}};
            rsp_cout_r    <= 1'b0;
            rsp_overf_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            if (state_r == S_IDLE && req_valid) begin
                ope1_r    <= req_a;
                ope2_r    <= req_b;
                add_sub_r <= req_sub;
            end
            if (state_r == S_ISSUE) begin
                timer_r <= {TW{1'b0}};
            end else if (state_r == S_WAIT) begin
                timer_r <= timer_r + TW'(1);
            end
            if (state_r == S_WAIT) begin
                if (complete_in) begin
                    rsp_sum_r     <= sum_in;
                    rsp_cout_r    <= cout_in;
                    rsp_overf_r   <= overf_in;
                    rsp_timeout_r <= 1'b0;
                end else if (timer_last_s) begin
                    rsp_sum_r     <= {WIDTH{1'b0}};
                    rsp_cout_r    <= 1'b0;
                    rsp_overf_r   <= 1'b0;
                    rsp_timeout_r <= 1'b1;
                end
            end
        end
    end

`ifdef CHECK_EN
    // Returns {overf, cout, sum}; subtraction is a + ~b + 1
    function automatic logic [WIDTH+1:0] golden_add(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             sub);
        logic [WIDTH-1:0] bx;
        logic [WIDTH:0]   r;
        logic             ov;
        bx = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        ov = (a[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return {ov, r};
    endfunction

    logic [WIDTH+1:0] gold_s;
    logic             mismatch_s;
    logic             chk_r;
    logic [ERR_W-1:0] err_r;
    logic             err_full_s;

    assign err_full_s   = (err_r == {ERR_W{1'b1}});
    assign chk_mismatch = chk_r;
    assign err_count    = err_r;

    // Golden comparison against what the adder returns
    always_comb begin
        gold_s     = golden_add(ope1_r, ope2_r, add_sub_r);
        mismatch_s = (gold_s[WIDTH-1:0] != sum_in) || (gold_s[WIDTH] != cout_in) ||
                     (gold_s[WIDTH+1] != overf_in);
    end

    // Mismatch flag and saturating error counter, updated on capture or timeout
    always_ff @(posedge clock) begin
        if (reset) begin
            chk_r <= 1'b0;
            err_r <= {ERR_W{1'b0}};
        end else if (state_r == S_WAIT) begin
            if (complete_in) begin
                chk_r <= mismatch_s;
                if (mismatch_s && !err_full_s) err_r <= err_r + ERR_W'(1);
            end else if (timer_last_s) begin
                chk_r <= 1'b0;
                if (!err_full_s) err_r <= err_r + ERR_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_adder_initiator.sv
// Directed bench for cond_adder_initiator with a behavioural adder answering a fixed delay after start.
module tb_cond_adder_initiator;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_sub;
    logic [63:0] ope1;
    logic [63:0] ope2;
    logic        add_sub;
    logic        Cin;
    logic        start;
    logic [63:0] sum_in;
    logic        cout_in;
    logic        overf_in;
    logic        complete_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_overf;
    logic        rsp_timeout;
    logic        busy;
`ifdef CHECK_EN
    logic        chk_mismatch;
    logic [15:0] err_count;
`endif

    int tests = 0;
    int fails = 0;
    int cyc;
    int nstart;

    // adder model controls
    int   adder_delay = 3;
    logic adder_en    = 1'b1;
    logic fault       = 1'b0;
    int   cnt         = 0;

    cond_adder_initiator dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .ope1(ope1), .ope2(ope2), .add_sub(add_sub), .Cin(Cin), .start(start),
        .sum_in(sum_in), .cout_in(cout_in), .overf_in(overf_in), .complete_in(complete_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_overf(rsp_overf),
        .rsp_timeout(rsp_timeout), .busy(busy)
`ifdef CHECK_EN
        , .chk_mismatch(chk_mismatch), .err_count(err_count)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural adder: complete pulses adder_delay negedges after start is seen
    always @(negedge clock) begin
        logic [63:0] bx;
        logic [64:0] r;
        complete_in = 1'b0;
        if (start) begin
            cnt = adder_delay;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0 && adder_en) begin
                bx          = add_sub ? ~ope2 : ope2;
                r           = {1'b0, ope1} + {1'b0, bx} + {64'd0, add_sub};
                sum_in      = r[63:0] ^ {63'd0, fault};
                cout_in     = r[64];
                overf_in    = (ope1[63] == bx[63]) && (r[63] != ope1[63]);
                complete_in = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [63:0] a, input logic [63:0] b, input logic s);
        req_a     = a;
        req_b     = b;
        req_sub   = s;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int c, output int ns);
        c  = 0;
        ns = 0;
        while (!rsp_valid && c < 100) begin
            if (start) ns++;
            @(negedge clock);
            c++;
        end
        chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    initial begin
        clock       = 1'b0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_a       = 64'd0;
        req_b       = 64'd0;
        req_sub     = 1'b0;
        rsp_ready   = 1'b0;
        sum_in      = 64'd0;
        cout_in     = 1'b0;
        overf_in    = 1'b0;
        complete_in = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_start", {63'd0, start}, 64'd0);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_sum", rsp_sum, 64'd0);
        chk("reset_ope1", ope1, 64'd0);
        chk("reset_cin", {63'd0, Cin}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // 2+2, adder delay 3: start at ISSUE, rsp_valid 4 cycles later
        do_req(64'd2, 64'd2, 1'b0);
        chk("2p2_start", {63'd0, start}, 64'd1);
        wait_rsp(cyc, nstart);
        chk("2p2_latency", 64'(cyc), 64'd4);
        chk("2p2_nstart", 64'(nstart), 64'd1);
        chk("2p2_sum", rsp_sum, 64'd4);
        chk("2p2_cout", {63'd0, rsp_cout}, 64'd0);
        chk("2p2_overf", {63'd0, rsp_overf}, 64'd0);
        chk("2p2_timeout", {63'd0, rsp_timeout}, 64'd0);
`ifdef CHECK_EN
        chk("2p2_mismatch", {63'd0, chk_mismatch}, 64'd0);
        chk("2p2_err", {48'd0, err_count}, 64'd0);
`endif
        take_rsp();
        chk("2p2_idle", {63'd0, busy}, 64'd0);

        // 25+25 right after
        do_req(64'd25, 64'd25, 1'b0);
        wait_rsp(cyc, nstart);
        chk("25p25_nstart", 64'(nstart), 64'd1);
        chk("25p25_sum", rsp_sum, 64'd50);
        take_rsp();

        // 5-7
        do_req(64'd5, 64'd7, 1'b1);
        chk("5m7_add_sub", {63'd0, add_sub}, 64'd1);
        chk("5m7_ope2", ope2, 64'd7);
        wait_rsp(cyc, nstart);
        chk("5m7_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("5m7_cout", {63'd0, rsp_cout}, 64'd0);
        chk("5m7_overf", {63'd0, rsp_overf}, 64'd0);
        take_rsp();

        // signed overflow
        do_req(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_rsp(cyc, nstart);
        chk("ovf_sum", rsp_sum, 64'h8000_0000_0000_0000);
        chk("ovf_overf", {63'd0, rsp_overf}, 64'd1);
        chk("ovf_cout", {63'd0, rsp_cout}, 64'd0);
        take_rsp();

`ifdef CHECK_EN
        // faulted adder sum must be flagged
        fault = 1'b1;
        do_req(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_rsp(cyc, nstart);
        chk("fault_mismatch", {63'd0, chk_mismatch}, 64'd1);
        chk("fault_err", {48'd0, err_count}, 64'd1);
        take_rsp();
        fault = 1'b0;
`endif

        // timeout: complete never comes
        adder_en = 1'b0;
        do_req(64'd10, 64'd20, 1'b0);
        wait_rsp(cyc, nstart);
        chk("to_latency", 64'(cyc), 64'd17);
        chk("to_flag", {63'd0, rsp_timeout}, 64'd1);
        chk("to_sum", rsp_sum, 64'd0);
        chk("to_cout", {63'd0, rsp_cout}, 64'd0);
`ifdef CHECK_EN
        chk("to_err", {48'd0, err_count}, 64'd2);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("to_hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("to_hold_flag", {63'd0, rsp_timeout}, 64'd1);
            chk("to_hold_sum", rsp_sum, 64'd0);
        end
        take_rsp();

        // reset while in WAIT
        do_req(64'd9, 64'd9, 1'b0);
        repeat (3) @(negedge clock);
        chk("rst_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_start", {63'd0, start}, 64'd0);
`ifdef CHECK_EN
        chk("rst_err", {48'd0, err_count}, 64'd0);
`endif
        adder_en = 1'b1;
        @(negedge clock);
        do_req(64'd1, 64'd1, 1'b0);
        wait_rsp(cyc, nstart);
        chk("1p1_sum", rsp_sum, 64'd2);
        chk("1p1_timeout", {63'd0, rsp_timeout}, 64'd0);
        take_rsp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
